// File: rtl/memory_arbiter_pkg.sv
// Shared types for memory_arbiter: FSM state encoding and requester indices.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } arb_state_t;

    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

endpackage

// File: rtl/memory_arbiter_picker.sv
// Combinational winner selection for memory_arbiter.
// Round-robin tie-break when MEMORY_ARBITER_ROUND_ROBIN_EN is defined, else m0 fixed priority.
module arbiter_picker
    import memory_arbiter_pkg::*;
(
    input  logic [1:0] request,
    input  logic       last_owner,
    output logic       winner,
    output logic       any
);

`ifndef MEMORY_ARBITER_ROUND_ROBIN_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    always_comb begin
        any    = |request;
        winner = ARB_M0;
        if (request == 2'b11) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            winner = ~last_owner;
`else
            winner = ARB_M0;
`endif
        end else if (request[1]) begin
            winner = ARB_M1;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Two-requester arbiter for the single memory port; one transaction outstanding at a time.
// Tie-break policy is selected by MEMORY_ARBITER_ROUND_ROBIN_EN (see arbiter_picker).
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      m0_request,
    input  logic                      m0_enable,
    input  logic                      m0_command,
    input  logic [ADDRESS_WIDTH-1:0]  m0_address,
    input  logic [DATA_WIDTH-1:0]     m0_write_data,
    input  logic [DATA_WIDTH/8-1:0]   m0_write_strobe,
    output logic                      m0_ready,
    output logic                      m0_valid,

    input  logic                      m1_request,
    input  logic                      m1_enable,
    input  logic                      m1_command,
    input  logic [ADDRESS_WIDTH-1:0]  m1_address,
    input  logic [DATA_WIDTH-1:0]     m1_write_data,
    input  logic [DATA_WIDTH/8-1:0]   m1_write_strobe,
    output logic                      m1_ready,
    output logic                      m1_valid,

    output logic [DATA_WIDTH-1:0]     read_data,

    input  logic                      memory_ready,
    input  logic                      memory_valid,
    input  logic [DATA_WIDTH-1:0]     memory_read_data,
    output logic                      memory_enable,
    output logic                      memory_command,
    output logic [ADDRESS_WIDTH-1:0]  memory_address,
    output logic [DATA_WIDTH-1:0]     memory_write_data,
    output logic [DATA_WIDTH/8-1:0]   memory_write_strobe,

    output logic                      debug_owner,
    output logic [1:0]                debug_state
);

    arb_state_t state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_owner_q, last_owner_d;
    logic       winner, any;
    logic       owner_request, owner_enable;
    logic       grant_ready, issue, active;

    arbiter_picker u_picker (
        .request    ({m1_request, m0_request}),
        .last_owner (last_owner_q),
        .winner     (winner),
        .any        (any)
    );

    assign owner_request = (owner_q == ARB_M1) ? m1_request : m0_request;
    assign owner_enable  = (owner_q == ARB_M1) ? m1_enable  : m0_enable;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= ARB_M0;
            last_owner_q <= ARB_M1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        grant_ready  = 1'b0;
        issue        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    owner_d = winner;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                grant_ready = memory_ready;
                // An enable while memory_ready is low never reaches memory.
                issue       = owner_enable && memory_ready;
                if (issue) begin
                    last_owner_d = owner_q;
                    state_d      = memory_valid ? IDLE : BUSY;
                end else if (!owner_request) begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (memory_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign active   = (state_q != IDLE) && !reset;

    assign m0_ready = grant_ready && !reset && (owner_q == ARB_M0);
    assign m1_ready = grant_ready && !reset && (owner_q == ARB_M1);
    assign m0_valid = memory_valid && active && (owner_q == ARB_M0);
    assign m1_valid = memory_valid && active && (owner_q == ARB_M1);

    assign memory_enable       = issue && !reset;
    assign memory_command      = (owner_q == ARB_M1) ? m1_command      : m0_command;
    assign memory_address      = (owner_q == ARB_M1) ? m1_address      : m0_address;
    assign memory_write_data   = (owner_q == ARB_M1) ? m1_write_data   : m0_write_data;
    assign memory_write_strobe = (owner_q == ARB_M1) ? m1_write_strobe : m0_write_strobe;

    assign read_data   = memory_read_data;
    assign debug_owner = owner_q;
    assign debug_state = state_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: directed scenarios, then randomized traffic from two requesters.
module tb_memory_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int N_TRANS = 40;

    logic clk = 1'b0;
    logic reset;
    logic          req [2];
    logic          en  [2];
    logic          cmd [2];
    logic [AW-1:0] addr[2];
    logic [DW-1:0] wd  [2];
    logic [SW-1:0] st  [2];
    wire  [1:0]    rdy;
    wire  [1:0]    vld;
    logic [DW-1:0] read_data;
    logic          memory_ready, memory_valid;
    logic [DW-1:0] memory_read_data;
    logic          memory_enable, memory_command;
    logic [AW-1:0] memory_address;
    logic [DW-1:0] memory_write_data;
    logic [SW-1:0] memory_write_strobe;
    logic          debug_owner;
    logic [1:0]    debug_state;

    always #5 clk = ~clk;

    memory_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_request(req[0]), .m0_enable(en[0]), .m0_command(cmd[0]), .m0_address(addr[0]),
        .m0_write_data(wd[0]), .m0_write_strobe(st[0]), .m0_ready(rdy[0]), .m0_valid(vld[0]),
        .m1_request(req[1]), .m1_enable(en[1]), .m1_command(cmd[1]), .m1_address(addr[1]),
        .m1_write_data(wd[1]), .m1_write_strobe(st[1]), .m1_ready(rdy[1]), .m1_valid(vld[1]),
        .read_data(read_data),
        .memory_ready(memory_ready), .memory_valid(memory_valid), .memory_read_data(memory_read_data),
        .memory_enable(memory_enable), .memory_command(memory_command), .memory_address(memory_address),
        .memory_write_data(memory_write_data), .memory_write_strobe(memory_write_strobe),
        .debug_owner(debug_owner), .debug_state(debug_state)
    );

    typedef struct {
        bit            m;
        bit            cmd;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [SW-1:0] st;
    } iss_t;
    typedef struct {
        bit            m;
        logic [DW-1:0] rd;
    } rsp_t;

    iss_t issue_q[$];
    rsp_t rsp_q[$];
    bit   last_model;
    bit   done[2];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic abort_run(input string name);
        total++;
        bad++;
        $display("FAIL %s: got no response want response within bound", name);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    // Memory side: checks each issued command against the issuing requester, answers after 0..3 cycles.
    task automatic mem_model();
        int   cnt = 0;
        bit   pend = 1'b0;
        iss_t e;
        rsp_t r;
        forever begin
            @(posedge clk);
            #1;
            memory_valid = 1'b0;
            memory_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            #1;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    memory_valid = 1'b1;
                    pend = 1'b0;
                end
            end else if (memory_enable) begin
                if (issue_q.size() == 0) begin
                    check("enable_unexpected", memory_enable, 1'b0);
                end else begin
                    e = issue_q.pop_front();
                    check("mem_command", memory_command, e.cmd);
                    check("mem_address", memory_address, e.a);
                    check("mem_wdata", memory_write_data, e.wd);
                    check("mem_strobe", memory_write_strobe, e.st);
                    r.m  = e.m;
                    r.rd = $urandom;
                    memory_read_data = r.rd;
                    rsp_q.push_back(r);
                    cnt = $urandom_range(0, 3);
                    if (cnt == 0) memory_valid = 1'b1;
                    else pend = 1'b1;
                end
            end
        end
    endtask

    // Response monitor plus arbitration-policy check on every IDLE->GRANT step.
    task automatic monitor();
        logic [1:0] prev_state = 2'd0;
        logic [1:0] prev_req   = 2'b00;
        logic       exp_w;
        rsp_t       r;
        forever begin
            @(negedge clk);
            #3;
            if (debug_state == 2'd1 && prev_state == 2'd0) begin
                if (prev_req == 2'b11) exp_w = RR ? ~last_model : 1'b0;
                else exp_w = prev_req[1];
                check("grant_winner", debug_owner, exp_w);
            end
            if (vld != 2'b00) begin
                if (rsp_q.size() == 0) begin
                    check("valid_unexpected", vld, 2'b00);
                end else begin
                    r = rsp_q.pop_front();
                    check("valid_route", vld, r.m ? 2'b10 : 2'b01);
                    check("read_data", read_data, r.rd);
                    done[r.m] = 1'b1;
                end
            end
            prev_state = debug_state;
            prev_req   = {req[1], req[0]};
        end
    endtask

    task automatic drive(input int i, input int n);
        bit   abort_req;
        int   w;
        iss_t e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            abort_req = ($urandom_range(0, 7) == 0);
            cmd[i]  = $urandom;
            addr[i] = $urandom;
            wd[i]   = $urandom;
            st[i]   = $urandom;
            req[i]  = 1'b1;
            if (abort_req) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                req[i] = 1'b0;
            end else begin
                w = 0;
                while (!rdy[i]) begin
                    w++;
                    if (w > 300) abort_run(i == 0 ? "m0_ready_wait" : "m1_ready_wait");
                    @(negedge clk);
                end
                en[i] = 1'b1;
                e.m = (i == 1); e.cmd = cmd[i]; e.a = addr[i]; e.wd = wd[i]; e.st = st[i];
                issue_q.push_back(e);
                last_model = (i == 1);
                @(posedge clk);
                #1;
                en[i]  = 1'b0;
                req[i] = 1'b0;
                w = 0;
                while (!done[i]) begin
                    @(negedge clk);
                    #4;
                    w++;
                    if (w > 50) abort_run(i == 0 ? "m0_valid_wait" : "m1_valid_wait");
                end
                done[i] = 1'b0;
            end
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; en[i] = 1'b0; cmd[i] = 1'b0;
            addr[i] = '0; wd[i] = '0; st[i] = '0; done[i] = 1'b0;
        end
        memory_ready = 1'b1; memory_valid = 1'b0; memory_read_data = '0;
        tick(); tick();
        reset = 1'b0;
        settle();
        check("rst_ready", rdy, 2'b00);
        check("rst_valid", vld, 2'b00);
        check("rst_menable", memory_enable, 1'b0);
        check("rst_state", debug_state, 2'd0);
        check("rst_owner", debug_owner, 1'b0);

        // m0 read of 0x100, valid three cycles after enable
        tick(); req[0] = 1'b1; cmd[0] = 1'b0; addr[0] = 32'h100; settle();
        check("d2_no_early_ready", rdy, 2'b00);
        tick(); en[0] = 1'b1; settle();
        check("d2_ready", rdy, 2'b01);
        check("d2_address", memory_address, 32'h100);
        check("d2_menable", memory_enable, 1'b1);
        tick(); en[0] = 1'b0; req[0] = 1'b0; settle();
        check("d2_busy", {debug_state, rdy, memory_enable}, {2'd2, 2'b00, 1'b0});
        tick(); settle();
        tick(); memory_valid = 1'b1; memory_read_data = 32'hDEADBEEF; settle();
        check("d2_valid", vld, 2'b01);
        check("d2_read_data", read_data, 32'hDEADBEEF);
        tick(); memory_valid = 1'b0; settle();
        check("d2_idle", debug_state, 2'd0);

        // zero-latency memory
        tick(); req[0] = 1'b1; settle();
        tick(); en[0] = 1'b1; memory_valid = 1'b1; memory_read_data = 32'hCAFE0001; settle();
        check("d3_grant_state", debug_state, 2'd1);
        check("d3_valid", vld, 2'b01);
        tick(); en[0] = 1'b0; memory_valid = 1'b0; req[0] = 1'b0; settle();
        check("d3_idle", {debug_state, vld}, {2'd0, 2'b00});

        // m1 write while m0 requests mid-BUSY
        tick(); req[1] = 1'b1; cmd[1] = 1'b1; addr[1] = 32'h200; wd[1] = 32'h12345678; st[1] = 4'b0011; settle();
        tick(); en[1] = 1'b1; settle();
        check("d4_ready1", rdy, 2'b10);
        check("d4_write", {memory_enable, memory_command, memory_address, memory_write_data, memory_write_strobe},
              {1'b1, 1'b1, 32'h200, 32'h12345678, 4'b0011});
        tick(); en[1] = 1'b0; req[0] = 1'b1; addr[0] = 32'h300; settle();
        check("d4_busy_ready", rdy, 2'b00);
        tick(); memory_valid = 1'b1; memory_read_data = 32'h0; settle();
        check("d4_valid", vld, 2'b10);
        check("d4_addr_hold", memory_address, 32'h200);
        tick(); memory_valid = 1'b0; req[1] = 1'b0; settle();
        check("d4_bubble", {debug_state, rdy}, {2'd0, 2'b00});
        tick(); settle();
        check("d4_m0_ready", rdy, 2'b01);

        // owner drops request while memory_ready=0; its enable must be ignored
        tick(); memory_ready = 1'b0; en[0] = 1'b1; req[0] = 1'b0; settle();
        check("d5_ready_low", rdy, 2'b00);
        check("d5_no_enable", memory_enable, 1'b0);
        tick(); en[0] = 1'b0; memory_ready = 1'b1; req[0] = 1'b1; req[1] = 1'b1; settle();
        check("d5_dropped_idle", debug_state, 2'd0);
        tick(); req[0] = 1'b0; req[1] = 1'b0; settle();
        check("d5_tie_owner", {debug_state, debug_owner}, {2'd1, 1'b0});

        // reset in BUSY, stray memory_valid afterwards
        tick(); req[1] = 1'b1; cmd[1] = 1'b0; settle();
        tick(); en[1] = 1'b1; settle();
        check("d6_ready1", rdy, 2'b10);
        tick(); en[1] = 1'b0; req[1] = 1'b0; reset = 1'b1; settle();
        tick(); reset = 1'b0; memory_valid = 1'b1; settle();
        check("d6_valids", vld, 2'b00);
        check("d6_state_owner", {debug_state, debug_owner}, {2'd0, 1'b0});
        tick(); memory_valid = 1'b0;

        last_model = 1'b1;
        fork
            mem_model();
            monitor();
        join_none
        fork
            drive(0, N_TRANS);
            drive(1, N_TRANS);
        join
        repeat (10) tick();
        check("sb_issue_drained", issue_q.size(), 0);
        check("sb_rsp_drained", rsp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
